// File: rtl/mrc_pkg.sv
// Shared op codes and FSM state type for the multiply/divide/sqrt unit.
package mrc_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StLoadY,
    StCompute,
    StDone
  } state_e;

endpackage

// File: rtl/mrc_if.sv
// Operand/result handshake bundle between a controller (master) and mrc_unit (slave).
interface mrc_if #(
  parameter int unsigned WORD_LENGTH = 16
) ();
  logic                       start;
  logic                       load;
  logic [WORD_LENGTH-1:0]     Data;
  logic [1:0]                 op;
  logic                       ready;
  logic [2*WORD_LENGTH-1:0]   Result;
  logic                       x;
  logic                       y;
  logic                       error;

  modport master (
    output start, load, Data, op,
    input  ready, Result, x, y, error
  );

  modport slave (
    input  start, load, Data, op,
    output ready, Result, x, y, error
  );
endinterface

// File: rtl/mrc_datapath.sv
// Operand, accumulator and counter registers with one iteration step per cycle.
// The sqrt step exists only when MRC_SQRT_EN is defined.
module mrc_datapath
  import mrc_pkg::*;
#(
  parameter int unsigned WordLength = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      ld_x_i,
  input  logic                      ld_y_i,
  input  logic                      step_i,
  input  logic                      clr_res_i,
  input  logic [1:0]                op_i,
  input  logic [WordLength-1:0]     data_i,
  output logic                      last_o,
  output logic [2*WordLength-1:0]   result_o
);
  localparam int unsigned W    = WordLength;
  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    x_q, x_d, y_q, y_d;
  logic [2*W-1:0]  acc_q, acc_d, res_q, res_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            xneg_q, xneg_d, neg_q, neg_d;

  logic [W-1:0]    data_mag, step_root, quo, rem;
  logic [W:0]      mul_sum, div_trial;
  logic [2*W-1:0]  step_acc, fin_res;
`ifdef MRC_SQRT_EN
  logic [W-1:0]    sq_rem, sq_trial;
  logic            sq_ge;
`endif

  assign data_mag = data_i[W-1] ? (~data_i + 1'b1) : data_i;
  assign last_o   = (cnt_q == CntW'(1));
  assign result_o = res_q;

  // acc holds {high, low}: mul {partial, multiplier}, div {remainder, quotient},
  // sqrt {remainder, radicand bits still to consume}; y_q is the sqrt root.
  always_comb begin : step_logic
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, x_q} : '0);
    div_trial = acc_q[2*W-1:W-1] - {1'b0, y_q};
    step_acc  = acc_q;
    step_root = y_q;
    fin_res   = '0;
    quo       = '0;
    rem       = '0;
`ifdef MRC_SQRT_EN
    sq_rem   = {acc_q[2*W-3:W], acc_q[W-1:W-2]};
    sq_trial = {y_q[W-3:0], 2'b01};
    sq_ge    = (sq_rem >= sq_trial);
`endif
    case (op_i)
      OP_MUL: begin
        step_acc = {mul_sum, acc_q[W-1:1]};
        fin_res  = neg_q ? (~step_acc + 1'b1) : step_acc;
      end
      OP_DIV: begin
        step_acc = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        quo      = neg_q  ? (~step_acc[W-1:0] + 1'b1)   : step_acc[W-1:0];
        rem      = xneg_q ? (~step_acc[2*W-1:W] + 1'b1) : step_acc[2*W-1:W];
        fin_res  = {rem, quo};
      end
`ifdef MRC_SQRT_EN
      OP_SQRT: begin
        step_acc  = {(sq_ge ? sq_rem - sq_trial : sq_rem), acc_q[W-3:0], 2'b00};
        step_root = {y_q[W-2:0], sq_ge};
        fin_res   = {step_acc[2*W-1:W], step_root};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin : next_state
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    xneg_d = xneg_q;
    neg_d  = neg_q;
    res_d  = res_q;
    if (ld_x_i) begin
      x_d    = data_mag;
      xneg_d = data_i[W-1];
      acc_d  = {{W{1'b0}}, data_i};
      y_d    = '0;
      cnt_d  = CntW'(W / 2);
    end else if (ld_y_i) begin
      y_d    = data_mag;
      neg_d  = xneg_q ^ data_i[W-1];
      cnt_d  = CntW'(W);
      acc_d  = {{W{1'b0}}, ((op_i == OP_MUL) ? data_mag : x_q)};
    end else if (step_i) begin
      acc_d = step_acc;
      y_d   = step_root;
      cnt_d = cnt_q - 1'b1;
      if (last_o) res_d = fin_res;
    end
    if (clr_res_i) res_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      xneg_q <= 1'b0;
      neg_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      xneg_q <= xneg_d;
      neg_q  <= neg_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: rtl/mrc_unit.sv
// Sequential signed multiply / divide / integer sqrt unit with a load-X/load-Y handshake.
// Define MRC_SQRT_EN to include sqrt; otherwise op 10 is rejected like the reserved op.
module mrc_unit
  import mrc_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 16
) (
  input logic  clk,
  input logic  reset,
  mrc_if.slave bus
);
  localparam int unsigned W = WORD_LENGTH;
`ifdef MRC_SQRT_EN
  localparam bit SqrtEn = 1'b1;
`else
  localparam bit SqrtEn = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            error_q, error_d;
  logic            x_err, y_err, last;
  logic            ld_x, ld_y, step, clr_res;
  logic            x_o, y_o, ready_o;
  logic [2*W-1:0]  result;

  // Errors detectable from the operand itself end the operation at the load edge.
  assign x_err = (bus.op == OP_RSVD) ||
                 ((bus.op == OP_SQRT) && (!SqrtEn || bus.Data[W-1]));
  assign y_err = (op_q == OP_DIV) && (bus.Data == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      error_q <= error_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    op_d    = op_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StLoadX;
      StLoadX: begin
        if (bus.load) begin
          op_d = bus.op;
          if (x_err) begin
            state_d = StDone;
            error_d = 1'b1;
          end else if (bus.op == OP_SQRT) begin
            state_d = StCompute;
          end else begin
            state_d = StLoadY;
          end
        end
      end
      StLoadY: begin
        if (bus.load) begin
          if (y_err) begin
            state_d = StDone;
            error_d = 1'b1;
          end else begin
            state_d = StCompute;
          end
        end
      end
      StCompute: if (last) state_d = StDone;
      StDone: begin
        if (bus.start) begin
          state_d = StLoadX;
          error_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin : outputs
    ld_x    = 1'b0;
    ld_y    = 1'b0;
    step    = 1'b0;
    clr_res = 1'b0;
    x_o     = 1'b0;
    y_o     = 1'b0;
    ready_o = 1'b0;
    unique case (state_q)
      StLoadX: begin
        x_o     = 1'b1;
        ld_x    = bus.load && !x_err;
        clr_res = bus.load && x_err;
      end
      StLoadY: begin
        y_o     = 1'b1;
        ld_y    = bus.load && !y_err;
        clr_res = bus.load && y_err;
      end
      StCompute: step = 1'b1;
      StDone:    ready_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.x      = x_o;
  assign bus.y      = y_o;
  assign bus.ready  = ready_o;
  assign bus.error  = error_q;
  assign bus.Result = result;

  mrc_datapath #(
    .WordLength (W)
  ) u_datapath (
    .clk_i     (clk),
    .reset_i   (reset),
    .ld_x_i    (ld_x),
    .ld_y_i    (ld_y),
    .step_i    (step),
    .clr_res_i (clr_res),
    .op_i      (op_q),
    .data_i    (bus.Data),
    .last_o    (last),
    .result_o  (result)
  );

endmodule

// File: tb/tb_mrc_unit.sv
// Self-checking bench for mrc_unit: directed vector table, protocol sequences and
// randomized operations against an integer-arithmetic reference model.
module tb_mrc_unit;
  localparam int unsigned WL = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mrc_if #(.WORD_LENGTH(WL)) bus ();

  mrc_unit #(.WORD_LENGTH(WL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] xv;
    logic [15:0] yv;
    int          wy;
    bit          poke;
    logic [31:0] res;
    bit          err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, SV '/' and '%' truncate toward zero.
  function automatic void model(input logic [1:0] op, input logic [15:0] xv,
                                input logic [15:0] yv, output logic [31:0] r, output bit e);
    int sx, sy, q, m, rt;
    longint p;
    sx = $signed(xv);
    sy = $signed(yv);
    r  = '0;
    e  = 1'b0;
    case (op)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        r = p[31:0];
      end
      2'b01: begin
        if (sy == 0) e = 1'b1;
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[15:0], q[15:0]};
        end
      end
      2'b10: begin
`ifdef MRC_SQRT_EN
        if (sx < 0) e = 1'b1;
        else begin
          rt = 0;
          while ((rt + 1) * (rt + 1) <= sx) rt++;
          m = sx - rt * rt;
          r = {m[15:0], rt[15:0]};
        end
`else
        e = 1'b1;
`endif
      end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic int exp_lat(input vec_t v);
    if (v.err) return (v.op == 2'b01) ? 2 + v.wy : 1;
    if (v.op == 2'b10) return WL / 2 + 1;
    return 1 + v.wy + WL + 1;
  endfunction

  // Latency counts the cycle after the X load edge as 1.
  task automatic run_op(input vec_t v, input string tag);
    int  lat;
    int  waited;
    bit  sawy;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " x_wait"}, 32'(bus.x), 32'd1);
    bus.load = 1'b1;
    bus.Data = v.xv;
    bus.op   = v.op;
    tick();
    bus.load = 1'b0;
    bus.Data = 16'($urandom);
    bus.op   = 2'($urandom);
    lat = 1;
    waited = 0;
    sawy = 1'b0;
    while (!bus.ready && lat < 200) begin
      if (bus.y) begin
        sawy = 1'b1;
        if (waited == v.wy) begin
          bus.load = 1'b1;
          bus.Data = v.yv;
        end else begin
          waited++;
        end
      end else if (!bus.x) begin
        bus.start = v.poke;
      end
      tick();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      lat++;
    end
    check({tag, " ready"}, 32'(bus.ready), 32'd1);
    check({tag, " result"}, bus.Result, v.res);
    check({tag, " error"}, 32'(bus.error), 32'(v.err));
    check({tag, " latency"}, 32'(lat), 32'(exp_lat(v)));
    check({tag, " y_phase"}, 32'(sawy), 32'(v.op == 2'b00 || v.op == 2'b01));
    tick();
    tick();
    check({tag, " hold_ready"}, 32'(bus.ready), 32'd1);
    check({tag, " hold_result"}, bus.Result, v.res);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   lat;

    bus.start = 1'b0;
    bus.load  = 1'b0;
    bus.Data  = '0;
    bus.op    = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst ready", 32'(bus.ready), 32'd0);
    check("rst x", 32'(bus.x), 32'd0);
    check("rst y", 32'(bus.y), 32'd0);
    check("rst error", 32'(bus.error), 32'd0);
    check("rst result", bus.Result, 32'd0);

    // {op, X, Y, Y-wait, start-during-compute, Result, error}
    tbl.push_back('{2'b00, 16'd16387, 16'd16387, 0, 1'b0, 32'h10018009, 1'b0});
    tbl.push_back('{2'b00, 16'hFFFD,  16'd5,     1, 1'b1, 32'hFFFFFFF1, 1'b0});
    tbl.push_back('{2'b01, 16'd100,   16'd7,     0, 1'b0, 32'h0002000E, 1'b0});
    tbl.push_back('{2'b01, 16'hFF9C,  16'd7,     2, 1'b1, 32'hFFFEFFF2, 1'b0});
    tbl.push_back('{2'b01, 16'd5,     16'd0,     0, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{2'b00, 16'h8000,  16'h8000,  0, 1'b0, 32'h40000000, 1'b0});
    tbl.push_back('{2'b01, 16'h8000,  16'hFFFF,  0, 1'b1, 32'h00008000, 1'b0});
    tbl.push_back('{2'b01, 16'd7,     16'hFFFE,  0, 1'b0, 32'h0001FFFD, 1'b0});
    tbl.push_back('{2'b00, 16'd1234,  16'd0,     3, 1'b0, 32'h00000000, 1'b0});
`ifdef MRC_SQRT_EN
    tbl.push_back('{2'b10, 16'd16387, 16'd0,     0, 1'b1, 32'h00030080, 1'b0});
`else
    tbl.push_back('{2'b10, 16'd16387, 16'd0,     0, 1'b0, 32'h00000000, 1'b1});
`endif
    tbl.push_back('{2'b10, 16'hFFFC,  16'd0,     0, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{2'b11, 16'd7,     16'd3,     0, 1'b0, 32'h00000000, 1'b1});

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Unit sits in DONE with error from the reserved op; a new start clears it.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart ready", 32'(bus.ready), 32'd0);
    check("restart x", 32'(bus.x), 32'd1);
    check("restart error", 32'(bus.error), 32'd0);

    // Load held for three edges: first edge takes X, second takes Y, third is ignored.
    bus.load = 1'b1;
    bus.op   = 2'b00;
    bus.Data = 16'd6;
    tick();
    check("hold y_wait", 32'(bus.y), 32'd1);
    bus.Data = 16'd7;
    tick();
    bus.Data = 16'd9;
    tick();
    bus.load = 1'b0;
    lat = 0;
    while (!bus.ready && lat < 100) begin
      tick();
      lat++;
    end
    check("hold ready", 32'(bus.ready), 32'd1);
    check("hold result", bus.Result, 32'd42);
    check("hold error", 32'(bus.error), 32'd0);

    // Reset in the middle of a multiply.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.load  = 1'b1;
    bus.Data  = 16'd1234;
    tick();
    bus.Data  = 16'd567;
    tick();
    bus.load  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst ready", 32'(bus.ready), 32'd0);
    check("midrst x", 32'(bus.x), 32'd0);
    check("midrst y", 32'(bus.y), 32'd0);
    check("midrst error", 32'(bus.error), 32'd0);
    check("midrst result", bus.Result, 32'd0);
    tick();
    check("midrst idle", 32'(bus.x), 32'd0);

    for (int i = 0; i < 40; i++) begin
      v.op   = 2'($urandom_range(0, 3));
      v.xv   = 16'($urandom);
      v.yv   = 16'($urandom);
      v.wy   = $urandom_range(0, 2);
      v.poke = 1'($urandom);
      case ($urandom_range(0, 6))
        0: v.xv = 16'h8000;
        1: v.yv = 16'hFFFF;
        2: v.yv = 16'h0000;
        3: v.xv[15] = 1'b0;
        default: ;
      endcase
      model(v.op, v.xv, v.yv, v.res, v.err);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mrc_unit.md
Name: mrc_unit

Overview:
- Sequential multi-operation arithmetic unit: signed multiply, signed divide, and integer square root on WORD_LENGTH-bit operands.
- Operands arrive one at a time on a shared Data bus, under a start/load handshake.
- The result is a 2*WORD_LENGTH-bit word qualified by ready and error.
- Sits as a coprocessor-style leaf block driven by a controller or a bench.

Parameters:
- WORD_LENGTH, 16, operand width (even, >=4); Result is 2*WORD_LENGTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE/DONE to begin a new operation.
- load  in  1  operand strobe; Data captured on any clk edge where load=1 in a load state.
- Data  in  WORD_LENGTH  operand value, two's complement.
- op  in  2  00 multiply, 01 divide, 10 sqrt, 11 reserved; sampled with X.
- ready  out  1  Result/error valid.
- Result  out  2*WORD_LENGTH  operation result.
- x  out  1  unit is waiting for operand X.
- y  out  1  unit is waiting for operand Y.
- error  out  1  operation invalid; qualified by ready.

Behaviour:
- Reset: state IDLE, all outputs 0, internal registers cleared.
- Reset mid-operation aborts immediately to IDLE.
- States: IDLE, LOAD_X, LOAD_Y, COMPUTE, DONE.
- IDLE: start=1 -> LOAD_X.
- LOAD_X: x=1. load=1 captures Data into X and op into an op register.
  - op 00/01 -> LOAD_Y.
  - op 10 -> COMPUTE.
  - op 11 -> DONE with error.
- LOAD_Y: y=1. load=1 captures Y -> COMPUTE.
  - Divide with Y=0 -> DONE with error; no compute.
- COMPUTE: iterative, one step per cycle; x=y=0.
  - Multiply: WORD_LENGTH cycles, shift-add on magnitudes, sign applied at end. Result = full signed product.
  - Divide: WORD_LENGTH cycles, restoring on magnitudes. Quotient truncated toward zero in Result[WL-1:0]; remainder with the dividend's sign in Result[2WL-1:WL].
  - Sqrt: WORD_LENGTH/2 cycles, digit-by-digit. Root in Result[WL-1:0], remainder (X - root^2) in the upper half.
  - Negative X for sqrt -> DONE with error.
- DONE: ready=1. Result and error are held stable until start=1, which clears ready/error and enters LOAD_X in the same transition.
- Error cases: Result=0, error=1, ready=1.
- Ignored inputs: start during LOAD_X, LOAD_Y or COMPUTE; load outside LOAD_X/LOAD_Y.
- Load timing: load held high for several cycles captures only once per state, since the state advances.
- x, y, ready are mutually exclusive and registered (Moore).
- Latency from the X load edge to ready:
  - multiply: 1 + Y-wait + WL + 1 cycles.
  - sqrt: WL/2 + 1 cycles.
  - error cases: 1 cycle after the offending load.
- Extremes:
  - (-2^(WL-1)) * (-2^(WL-1)) = 2^(2WL-2), fits.
  - (-2^(WL-1)) / -1: quotient wraps to -2^(WL-1), remainder 0, no error.

Optional Feature:
- MRC_SQRT_EN.
- Defined: the sqrt datapath is present, op 10 operates as above.
- Undefined: sqrt logic is removed and op 10 is treated as reserved (DONE, error=1, Result=0).

Decomposition:
- Package mrc_pkg:
  - op code constants OP_MUL, OP_DIV, OP_SQRT, OP_RSVD.
  - state enum type.
- One sub-module, mrc_datapath: holds the X/Y/accumulator/counter registers and the per-cycle step logic, with control inputs from the FSM in mrc_unit.

Test Plan:
- Multiply: op=00, X=16387, Y=16387 -> ready=1, Result=0x10018009, error=0.
- Signed multiply: X=-3, Y=5 -> Result=0xFFFFFFF1.
- Divide: op=01, X=100, Y=7 -> Result=0x0002000E; then X=-100, Y=7 -> quotient -14 (0xFFF2), remainder -2 (0xFFFE).
- Divide by zero: X=5, Y=0 -> ready=1, error=1, Result=0 one cycle after the Y load.
- Sqrt (MRC_SQRT_EN defined): X=16387 -> Result=0x00030080, no Y phase (y never asserts). X=-4 -> error=1. Without the macro, X=16387 with op=10 -> error=1.
- Protocol:
  - start pulsed during COMPUTE is ignored.
  - load held 3 cycles in LOAD_X captures once.
  - reset asserted mid-COMPUTE -> all outputs 0 next edge.
  - second start from DONE clears ready and raises x.
